copperv_cpu: RTL and testbench
==============================

# copperv_cpu

- Multi-cycle, in-order RV32I processor core: the CPU block of the copperv design.
- Fetches instructions over a read-only instruction bus and executes loads and stores over separate data-read and data-write buses.
- All three buses use valid/ready handshakes.
- The system crossbar maps memory and memory-mapped IO; this includes the test-status word at 0x8000, the UART byte at 0x8004 and syscall ports at 0xC000–0xC040.

## Interface
- BUS_WIDTH, 32: address/data width of all buses.
- BUS_RESP_WIDTH, 1: write-response width (value ignored by core).
- RESET_PC, 32'h0: address of first fetch.
- clk  in  1  core clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- ir_addr_valid  out  1  / ir_addr_ready  in  1  / ir_addr  out  32  instruction address channel.
- ir_data_valid  in  1  / ir_data_ready  out  1  / ir_data  in  32  instruction data channel.
- dr_addr_valid  out  1  / dr_addr_ready  in  1  / dr_addr  out  32  load address channel.
- dr_data_valid  in  1  / dr_data_ready  out  1  / dr_data  in  32  load data channel.
- dw_data_addr_valid  out  1  / dw_data_addr_ready  in  1  store request channel.
  - dw_addr  out  32: store address.
  - dw_data  out  32: lane-aligned store data.
  - dw_strobe  out  4: byte enables, bit i covers dw_data[8i+7:8i].
- dw_resp_valid  in  1  / dw_resp_ready  out  1  / dw_resp  in  BUS_RESP_WIDTH  store response channel.

## Operation
- Register file instance `regfile`, array `mem[0:31]` of 32 bits, readable hierarchically.
  - Benches read mem[28] (t3) as the test id.
  - x0 reads 0; writes to x0 are discarded.
  - Register contents are not cleared by reset.
- ISA: full RV32I integer set.
  - LUI, AUIPC, JAL, JALR (target bit0 cleared).
  - BEQ/BNE/BLT/BGE/BLTU/BGEU.
  - LB/LH/LW/LBU/LHU, SB/SH/SW.
  - All OP-IMM and OP ALU operations; shifts use the low 5 bits of the shift amount.
  - FENCE, ECALL, EBREAK, CSR and unknown opcodes execute as NOP (PC+4). No traps.
- FSM states: RESET → FETCH → FETCH_WAIT → EXEC → (LOAD → LOAD_WAIT | STORE → STORE_WAIT) → WB → FETCH.
  - Non-memory instructions go EXEC → WB.
- Arithmetic is 32-bit wrap-around; SLT/SLTI are signed, SLTU/SLTIU unsigned.
- Loads:
  - dr_addr = effective address with bits[1:0] cleared.
  - Byte/half extracted from the lane selected by addr[1:0], then sign- or zero-extended.
  - Halfword with addr[1]=1 uses bits[31:16].
- Stores:
  - dw_addr = effective address with bits[1:0] cleared.
  - SB: strobe = 1<<addr[1:0], data byte replicated on all lanes.
  - SH: strobe = 0011 or 1100 by addr[1], half replicated.
  - SW: strobe = 1111.
- Misaligned accesses are not trapped; offset bits beyond the access size are ignored.
- dw_resp value is ignored; any response completes the store.

## Timing
- Reset (rst=0), asynchronously:
  - State = RESET; PC = RESET_PC.
  - All valid/ready outputs 0.
  - ir_addr, dr_addr, dw_addr, dw_data = 0; dw_strobe = 0.
- First rising edge after rst=1: enter FETCH, ir_addr_valid=1, ir_addr=PC.
- Handshake rules:
  - A transfer occurs on a rising edge where valid && ready.
  - Valid and payload are held stable until the transfer; valid drops the cycle after it.
  - Ready outputs are 1 exactly in the corresponding wait state (FETCH_WAIT, LOAD_WAIT, STORE_WAIT).
  - Data accepted on that edge.
- The core never issues overlapping requests; one outstanding transaction at a time.
- A channel's data/response can complete no earlier than the cycle after its address handshake.
- Latency with zero-wait-state slaves:
  - ALU/jump/branch: 4 cycles (FETCH, FETCH_WAIT, EXEC, WB).
  - Load/store: 6 cycles.
- PC updates and the rd write occur on the WB edge.
- Reset asserted mid-transaction aborts it immediately; no completion is expected.

## Test plan
- Reset: hold rst=0 ten cycles → all valid/ready outputs 0. Release → ir_addr_valid=1 with ir_addr=0x0 on the next cycle.
- Pass-flag store: program LUI x5,0x8; LUI x6,0x1000; ADDI x6,x6,1; SW x6,0(x5) → dw_addr=0x8000, dw_data=0x01000001, dw_strobe=1111.
- Byte store: x5=0x8000, x7=0x41, SB x7,5(x5) → dw_addr=0x8004, strobe=0010, dw_data=0x41414141.
- Loads: LW from 0xC040 returning 0x1 → rd=1. LB from 0x100 with dr_data=0x00008000, offset 1 → rd=0xFFFFFF80. LBU from the same address → 0x80.
- Control flow:
  - BEQ x0,x0,+8 at PC 0x10 → next ir_addr=0x18.
  - JAL x1,+16 at 0x20 → x1=0x24, next fetch 0x30.
  - ADDI x0,x0,5 → x0 stays 0.
- Backpressure: hold ir_addr_ready=0 for 3 cycles → ir_addr_valid stays 1 with ir_addr stable. Delay dw_resp_valid 5 cycles → no new fetch until the response completes.

Source files
------------

// File: rtl/copperv_cpu.sv
// copperv_cpu: multi-cycle in-order RV32I core with valid/ready instruction,
// data-read and data-write buses. One bus transaction outstanding at a time.
//
// state      | meaning
// RESET      | held in reset, all handshakes idle
// FETCH      | present PC on instruction address channel
// FETCH_WAIT | wait for instruction word
// EXEC       | decode, ALU, branch/jump target, effective address
// LOAD       | present load address
// LOAD_WAIT  | wait for load data, extract lane
// STORE      | present store address/data/strobe
// STORE_WAIT | wait for any store response
// WB         | write rd, commit next PC
module copperv_cpu #(
  parameter int          BUS_WIDTH      = 32,
  parameter int          BUS_RESP_WIDTH = 1,
  parameter logic [31:0] RESET_PC       = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      ir_addr_valid,
  input  logic                      ir_addr_ready,
  output logic [BUS_WIDTH-1:0]      ir_addr,
  input  logic                      ir_data_valid,
  output logic                      ir_data_ready,
  input  logic [BUS_WIDTH-1:0]      ir_data,
  output logic                      dr_addr_valid,
  input  logic                      dr_addr_ready,
  output logic [BUS_WIDTH-1:0]      dr_addr,
  input  logic                      dr_data_valid,
  output logic                      dr_data_ready,
  input  logic [BUS_WIDTH-1:0]      dr_data,
  output logic                      dw_data_addr_valid,
  input  logic                      dw_data_addr_ready,
  output logic [BUS_WIDTH-1:0]      dw_addr,
  output logic [BUS_WIDTH-1:0]      dw_data,
  output logic [BUS_WIDTH/8-1:0]    dw_strobe,
  input  logic                      dw_resp_valid,
  output logic                      dw_resp_ready,
  input  logic [BUS_RESP_WIDTH-1:0] dw_resp
);

  typedef enum logic [3:0] {
    RESET, FETCH, FETCH_WAIT, EXEC, LOAD, LOAD_WAIT, STORE, STORE_WAIT, WB
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6f;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_next, pc_plus4;
  logic [31:0] instr;
  logic [31:0] result;
  logic        rd_we;
  logic [1:0]  ea_lo;

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;

  logic [31:0] exec_result, exec_npc, ea;
  logic        exec_we, is_load, is_store, br_taken;
  logic [31:0] st_data, ld_data;
  logic [3:0]  st_strobe;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        rf_we;

  logic unused_resp;
  assign unused_resp = ^dw_resp;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u  = {instr[31:12], 12'd0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign pc_plus4 = pc + 32'd4;

  // Register file; x0 is never written and always reads as zero.
  assign rf_we = (state == WB) && rd_we;
  if (1) begin : regfile
    logic [31:0] mem [0:31];
    always_ff @(posedge clk) begin
      if (rf_we && rd != 5'd0) mem[rd] <= result;
    end
    assign rs1_val = (rs1 == 5'd0) ? 32'd0 : mem[rs1];
    assign rs2_val = (rs2 == 5'd0) ? 32'd0 : mem[rs2];
  end

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic sub,
                                      input logic arith);
    logic [31:0] r;
    case (f3)
      3'd0:    r = sub ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'd0, $signed(a) < $signed(b)};
      3'd3:    r = {31'd0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = arith ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  always_comb begin
    br_taken = 1'b0;
    case (funct3)
      3'd0:    br_taken = rs1_val == rs2_val;
      3'd1:    br_taken = rs1_val != rs2_val;
      3'd4:    br_taken = $signed(rs1_val) < $signed(rs2_val);
      3'd5:    br_taken = $signed(rs1_val) >= $signed(rs2_val);
      3'd6:    br_taken = rs1_val < rs2_val;
      3'd7:    br_taken = rs1_val >= rs2_val;
      default: br_taken = 1'b0;
    endcase
  end

  // Anything not decoded here (FENCE, SYSTEM, unknown) falls through as a NOP.
  always_comb begin
    exec_result = 32'd0;
    exec_npc    = pc_plus4;
    exec_we     = 1'b0;
    is_load     = 1'b0;
    is_store    = 1'b0;
    ea          = rs1_val + imm_i;
    case (opcode)
      OP_LUI:   begin exec_result = imm_u;      exec_we = 1'b1; end
      OP_AUIPC: begin exec_result = pc + imm_u; exec_we = 1'b1; end
      OP_JAL: begin
        exec_result = pc_plus4;
        exec_npc    = pc + imm_j;
        exec_we     = 1'b1;
      end
      OP_JALR: begin
        exec_result = pc_plus4;
        exec_npc    = (rs1_val + imm_i) & ~32'd1;
        exec_we     = 1'b1;
      end
      OP_BRANCH: begin
        if (br_taken) exec_npc = pc + imm_b;
      end
      OP_LOAD: begin
        is_load = 1'b1;
        exec_we = 1'b1;
      end
      OP_STORE: begin
        is_store = 1'b1;
        ea       = rs1_val + imm_s;
      end
      OP_IMM: begin
        exec_result = alu(rs1_val, imm_i, funct3, 1'b0, instr[30]);
        exec_we     = 1'b1;
      end
      OP_REG: begin
        exec_result = alu(rs1_val, rs2_val, funct3, instr[30], instr[30]);
        exec_we     = 1'b1;
      end
      default: ;
    endcase
  end

  // Narrow stores replicate the value on every lane; strobes pick the lane.
  always_comb begin
    st_data   = rs2_val;
    st_strobe = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_data   = {4{rs2_val[7:0]}};
        st_strobe = 4'b0001 << ea[1:0];
      end
      2'b01: begin
        st_data   = {2{rs2_val[15:0]}};
        st_strobe = ea[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (ea_lo)
      2'd0:    ld_byte = dr_data[7:0];
      2'd1:    ld_byte = dr_data[15:8];
      2'd2:    ld_byte = dr_data[23:16];
      default: ld_byte = dr_data[31:24];
    endcase
    ld_half = ea_lo[1] ? dr_data[31:16] : dr_data[15:0];
    case (funct3)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd4:    ld_data = {24'd0, ld_byte};
      3'd5:    ld_data = {16'd0, ld_half};
      default: ld_data = dr_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    ir_addr_valid      = 1'b0;
    ir_data_ready      = 1'b0;
    dr_addr_valid      = 1'b0;
    dr_data_ready      = 1'b0;
    dw_data_addr_valid = 1'b0;
    dw_resp_ready      = 1'b0;
    ir_addr            = '0;
    case (state)
      RESET: state_nxt = FETCH;
      FETCH: begin
        ir_addr_valid = 1'b1;
        ir_addr       = pc;
        if (ir_addr_ready) state_nxt = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ir_data_ready = 1'b1;
        if (ir_data_valid) state_nxt = EXEC;
      end
      EXEC: begin
        if (is_load)       state_nxt = LOAD;
        else if (is_store) state_nxt = STORE;
        else               state_nxt = WB;
      end
      LOAD: begin
        dr_addr_valid = 1'b1;
        if (dr_addr_ready) state_nxt = LOAD_WAIT;
      end
      LOAD_WAIT: begin
        dr_data_ready = 1'b1;
        if (dr_data_valid) state_nxt = WB;
      end
      STORE: begin
        dw_data_addr_valid = 1'b1;
        if (dw_data_addr_ready) state_nxt = STORE_WAIT;
      end
      STORE_WAIT: begin
        dw_resp_ready = 1'b1;
        if (dw_resp_valid) state_nxt = WB;
      end
      WB:      state_nxt = FETCH;
      default: state_nxt = RESET;
    endcase
  end

  // Bus payloads are captured in EXEC so they stay stable through the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RESET_PC;
      pc_next   <= RESET_PC;
      instr     <= 32'd0;
      result    <= 32'd0;
      rd_we     <= 1'b0;
      ea_lo     <= 2'd0;
      dr_addr   <= '0;
      dw_addr   <= '0;
      dw_data   <= '0;
      dw_strobe <= '0;
    end else begin
      if (state == FETCH_WAIT && ir_data_valid) instr <= ir_data;
      if (state == EXEC) begin
        result  <= exec_result;
        pc_next <= exec_npc;
        rd_we   <= exec_we;
        ea_lo   <= ea[1:0];
        if (is_load) dr_addr <= {ea[31:2], 2'b00};
        if (is_store) begin
          dw_addr   <= {ea[31:2], 2'b00};
          dw_data   <= st_data;
          dw_strobe <= st_strobe;
        end
      end
      if (state == LOAD_WAIT && dr_data_valid) result <= ld_data;
      if (state == WB) pc <= pc_next;
    end
  end

endmodule

// File: tb/tb_copperv_cpu.sv
// Bench for copperv_cpu: bus slave models with scoreboard queues for fetch,
// load and store traffic, driven by small hand-assembled programs.
module tb_copperv_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ir_addr_valid, ir_addr_ready, ir_data_valid, ir_data_ready;
  logic [31:0] ir_addr, ir_data;
  logic        dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic [31:0] dr_addr, dr_data;
  logic        dw_data_addr_valid, dw_data_addr_ready, dw_resp_valid, dw_resp_ready;
  logic [31:0] dw_addr, dw_data;
  logic [3:0]  dw_strobe;
  logic [0:0]  dw_resp;

  copperv_cpu dut (
    .clk(clk), .rst(rst),
    .ir_addr_valid(ir_addr_valid), .ir_addr_ready(ir_addr_ready), .ir_addr(ir_addr),
    .ir_data_valid(ir_data_valid), .ir_data_ready(ir_data_ready), .ir_data(ir_data),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .dw_data_addr_valid(dw_data_addr_valid), .dw_data_addr_ready(dw_data_addr_ready),
    .dw_addr(dw_addr), .dw_data(dw_data), .dw_strobe(dw_strobe),
    .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready), .dw_resp(dw_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_t;

  int          total = 0;
  int          bad = 0;
  logic [31:0] imem [0:63];
  st_t         exp_st[$];
  logic [31:0] exp_fetch[$];
  logic [31:0] exp_dr[$];
  logic [31:0] dr_resp_q[$];
  int          dw_delay_next = 0;
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          stall_len = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                        input logic [31:0] f3, input logic [31:0] rd,
                                        input logic [31:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                        input logic [31:0] op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                        input logic [31:0] rs1, input logic [31:0] f3,
                                        input logic [31:0] rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_006f;
  endtask

  task automatic push_st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    st_t e;
    e.addr = a; e.data = d; e.strb = s;
    exp_st.push_back(e);
  endtask

  // Instruction slave: one-cycle data latency, optional one-shot address stall.
  initial begin : ir_slave
    logic ax, dx;
    logic [31:0] a, e;
    int stall_left;
    ir_addr_ready = 1'b0; ir_data_valid = 1'b0; ir_data = 32'd0; stall_left = 0;
    forever begin
      @(negedge clk);
      ax = ir_addr_valid && ir_addr_ready;
      dx = ir_data_valid && ir_data_ready;
      a  = ir_addr;
      @(posedge clk); #1;
      if (!rst) begin
        ir_addr_ready = 1'b0; ir_data_valid = 1'b0; stall_left = 0;
      end else begin
        if (dx) ir_data_valid = 1'b0;
        if (ax) begin
          if (exp_fetch.size() > 0) begin
            e = exp_fetch.pop_front();
            chk("fetch_addr", a, e);
          end
          ir_data = imem[a[7:2]];
          ir_data_valid = 1'b1;
        end
        if (stall_left > 0) begin
          chk("stall_valid", 32'(ir_addr_valid), 1);
          chk("stall_addr", ir_addr, stall_addr);
          stall_left--;
        end
        if (stall_len > 0 && ir_addr_valid && ir_addr == stall_addr) begin
          stall_left = stall_len;
          stall_len = 0;
        end
        ir_addr_ready = (stall_left == 0);
      end
    end
  end

  initial begin : dr_slave
    logic ax, dx;
    logic [31:0] a, e;
    dr_addr_ready = 1'b0; dr_data_valid = 1'b0; dr_data = 32'd0;
    forever begin
      @(negedge clk);
      ax = dr_addr_valid && dr_addr_ready;
      dx = dr_data_valid && dr_data_ready;
      a  = dr_addr;
      @(posedge clk); #1;
      if (!rst) begin
        dr_addr_ready = 1'b0; dr_data_valid = 1'b0;
      end else begin
        if (dx) dr_data_valid = 1'b0;
        if (ax) begin
          if (exp_dr.size() > 0) begin
            e = exp_dr.pop_front();
            chk("load_addr", a, e);
          end else begin
            total++; bad++;
            $display("FAIL load_extra: actual addr=%h required=no load", a);
          end
          dr_data = (dr_resp_q.size() > 0) ? dr_resp_q.pop_front() : 32'd0;
          dr_data_valid = 1'b1;
        end
        dr_addr_ready = 1'b1;
      end
    end
  end

  // Store slave: compares each request against the scoreboard, optional response delay.
  initial begin : dw_slave
    logic ax, rx, pending;
    logic [31:0] a, d;
    logic [3:0] s;
    st_t e;
    int delay_left;
    dw_data_addr_ready = 1'b0; dw_resp_valid = 1'b0; dw_resp = 1'b0;
    pending = 1'b0; delay_left = 0;
    forever begin
      @(negedge clk);
      ax = dw_data_addr_valid && dw_data_addr_ready;
      rx = dw_resp_valid && dw_resp_ready;
      a = dw_addr; d = dw_data; s = dw_strobe;
      @(posedge clk); #1;
      if (!rst) begin
        dw_data_addr_ready = 1'b0; dw_resp_valid = 1'b0; pending = 1'b0; delay_left = 0;
      end else begin
        if (rx) dw_resp_valid = 1'b0;
        if (ax) begin
          if (exp_st.size() > 0) begin
            e = exp_st.pop_front();
            chk("store_addr", a, e.addr);
            chk("store_data", d, e.data);
            chk("store_strobe", 32'(s), 32'(e.strb));
          end else begin
            total++; bad++;
            $display("FAIL store_extra: actual addr=%h data=%h required=no store", a, d);
          end
          pending = 1'b1;
          delay_left = dw_delay_next;
          dw_delay_next = 0;
        end
        if (pending) begin
          if (delay_left == 0) begin
            dw_resp_valid = 1'b1;
            pending = 1'b0;
          end else begin
            chk("resp_wait_fetch", 32'(ir_addr_valid), 0);
            chk("resp_wait_ready", 32'(dw_resp_ready), 1);
            delay_left--;
          end
        end
        dw_data_addr_ready = 1'b1;
      end
    end
  end

  task automatic drain(input int budget);
    int c = 0;
    while ((exp_st.size() != 0 || exp_fetch.size() != 0 || exp_dr.size() != 0) && c < budget) begin
      @(posedge clk);
      c++;
    end
    repeat (20) @(posedge clk);
    #1;
    chk("stores_left", 32'(exp_st.size()), 0);
    chk("fetches_left", 32'(exp_fetch.size()), 0);
    chk("loads_left", 32'(exp_dr.size()), 0);
  endtask

  task automatic enter_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_st.delete(); exp_fetch.delete(); exp_dr.delete(); dr_resp_q.delete();
    clear_imem();
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;

    // Program A: pass flag, byte/half stores, x0 write, test id; fetch stall and slow store response.
    clear_imem();
    imem[0]  = enc_u(32'h8, 5, 32'h37);
    imem[1]  = enc_u(32'h1000, 6, 32'h37);
    imem[2]  = enc_i(1, 6, 0, 6, 32'h13);
    imem[3]  = enc_s(0, 6, 5, 2);
    imem[4]  = enc_i(32'h41, 0, 0, 7, 32'h13);
    imem[5]  = enc_s(5, 7, 5, 0);
    imem[6]  = enc_i(5, 0, 0, 0, 32'h13);
    imem[7]  = enc_s(0, 0, 5, 2);
    imem[8]  = enc_s(2, 7, 5, 1);
    imem[9]  = enc_i(7, 0, 0, 28, 32'h13);
    push_st(32'h8000, 32'h0100_0001, 4'b1111);
    push_st(32'h8004, 32'h4141_4141, 4'b0010);
    push_st(32'h8000, 32'h0000_0000, 4'b1111);
    push_st(32'h8000, 32'h0041_0041, 4'b1100);
    stall_addr = 32'h0000_000c;
    stall_len = 3;
    dw_delay_next = 5;

    repeat (10) @(posedge clk);
    #1;
    chk("rst_ir_addr_valid", 32'(ir_addr_valid), 0);
    chk("rst_ir_data_ready", 32'(ir_data_ready), 0);
    chk("rst_dr_addr_valid", 32'(dr_addr_valid), 0);
    chk("rst_dr_data_ready", 32'(dr_data_ready), 0);
    chk("rst_dw_valid", 32'(dw_data_addr_valid), 0);
    chk("rst_dw_resp_ready", 32'(dw_resp_ready), 0);
    chk("rst_ir_addr", ir_addr, 0);
    chk("rst_dr_addr", dr_addr, 0);
    chk("rst_dw_addr", dw_addr, 0);
    chk("rst_dw_data", dw_data, 0);
    chk("rst_dw_strobe", 32'(dw_strobe), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("first_fetch_valid", 32'(ir_addr_valid), 1);
    chk("first_fetch_addr", ir_addr, 32'h0);
    drain(3000);
    chk("test_id_a", dut.regfile.mem[28], 32'd7);

    // Program B: loads of every width, results echoed through stores to 0x0.
    enter_reset();
    imem[0]  = enc_u(32'hC, 5, 32'h37);
    imem[1]  = enc_i(32'h40, 5, 2, 8, 32'h03);
    imem[2]  = enc_s(0, 8, 0, 2);
    imem[3]  = enc_i(32'h100, 0, 0, 9, 32'h13);
    imem[4]  = enc_i(1, 9, 0, 10, 32'h03);
    imem[5]  = enc_s(0, 10, 0, 2);
    imem[6]  = enc_i(1, 9, 4, 11, 32'h03);
    imem[7]  = enc_s(0, 11, 0, 2);
    imem[8]  = enc_i(2, 9, 1, 12, 32'h03);
    imem[9]  = enc_s(0, 12, 0, 2);
    imem[10] = enc_i(3, 9, 5, 13, 32'h03);
    imem[11] = enc_s(0, 13, 0, 2);
    exp_dr.push_back(32'hC040); dr_resp_q.push_back(32'h0000_0001);
    exp_dr.push_back(32'h0100); dr_resp_q.push_back(32'h0000_8000);
    exp_dr.push_back(32'h0100); dr_resp_q.push_back(32'h0000_8000);
    exp_dr.push_back(32'h0100); dr_resp_q.push_back(32'h8001_0000);
    exp_dr.push_back(32'h0100); dr_resp_q.push_back(32'hABCD_1234);
    push_st(32'h0, 32'h0000_0001, 4'b1111);
    push_st(32'h0, 32'hFFFF_FF80, 4'b1111);
    push_st(32'h0, 32'h0000_0080, 4'b1111);
    push_st(32'h0, 32'hFFFF_8001, 4'b1111);
    push_st(32'h0, 32'h0000_ABCD, 4'b1111);
    rst = 1'b1;
    drain(3000);

    // Program C: ALU compares/shifts, taken branch, JAL link and target.
    enter_reset();
    imem[0]  = enc_i(-5, 0, 0, 2, 32'h13);
    imem[1]  = enc_i(3, 0, 0, 3, 32'h13);
    imem[2]  = enc_r(0, 3, 2, 2, 4);
    imem[3]  = enc_r(0, 3, 2, 3, 14);
    imem[4]  = enc_b(8, 0, 0, 0);
    imem[5]  = enc_i(99, 0, 0, 28, 32'h13);
    imem[6]  = enc_r(32'h20, 2, 3, 0, 15);
    imem[7]  = enc_i(35, 0, 0, 17, 32'h13);
    imem[8]  = enc_j(16, 1);
    imem[9]  = enc_i(99, 0, 0, 28, 32'h13);
    imem[10] = enc_i(99, 0, 0, 28, 32'h13);
    imem[11] = enc_i(99, 0, 0, 28, 32'h13);
    imem[12] = enc_s(0, 1, 0, 2);
    imem[13] = enc_s(0, 4, 0, 2);
    imem[14] = enc_s(0, 14, 0, 2);
    imem[15] = enc_s(0, 15, 0, 2);
    imem[16] = enc_r(0, 17, 2, 5, 18);
    imem[17] = enc_s(0, 18, 0, 2);
    imem[18] = enc_i(32'h401, 2, 5, 19, 32'h13);
    imem[19] = enc_s(0, 19, 0, 2);
    foreach (imem[i]) begin
      if (i <= 20 && i != 5 && i != 9 && i != 10 && i != 11)
        exp_fetch.push_back(32'(i * 4));
    end
    push_st(32'h0, 32'h0000_0024, 4'b1111);
    push_st(32'h0, 32'h0000_0001, 4'b1111);
    push_st(32'h0, 32'h0000_0000, 4'b1111);
    push_st(32'h0, 32'h0000_0008, 4'b1111);
    push_st(32'h0, 32'h1FFF_FFFF, 4'b1111);
    push_st(32'h0, 32'hFFFF_FFFD, 4'b1111);
    rst = 1'b1;
    drain(3000);
    chk("test_id_kept", dut.regfile.mem[28], 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
